// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch / decode / execute / memory / writeback sequencer
// for the single-issue ARM-subset CPU. Define CPU_CTRL_RETIRE_CNT_EN to add the
// retired_cnt output (instruction-boundary counter).
module cpu_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_load,
    output logic        dec_enable,
    input  logic [10:0] alu_ctl,
    input  logic        execute_flag,
    input  logic        cpsr_enable,
    output logic        alu_en,
    output logic        cpsr_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic [2:0]  state,
    output logic        fault,
`ifdef CPU_CTRL_RETIRE_CNT_EN
    output logic [31:0] retired_cnt,
`endif
    output logic [1:0]  fault_code
);

    localparam int unsigned ALU_W = 11;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned RET_W = 32;

    localparam logic [ALU_W-1:0] OP_DP_MAX = ALU_W'(13);
    localparam logic [ALU_W-1:0] OP_B      = ALU_W'(31);
    localparam logic [ALU_W-1:0] OP_BL     = ALU_W'(32);
    localparam logic [ALU_W-1:0] OP_LDR    = ALU_W'(41);
    localparam logic [ALU_W-1:0] OP_STR    = ALU_W'(42);

    localparam logic [1:0] FC_FETCH   = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_ILLEGAL = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // Instruction class plus the decoder condition/S-bit captured in DECODE
    typedef struct packed {
        logic dp;
        logic cmp;
        logic b;
        logic bl;
        logic ldr;
        logic str;
        logic cond;
        logic sbit;
    } cls_t;

    state_t             r_state;
    state_t             w_state_nxt;
    cls_t               r_cls;
    cls_t               w_cls_nxt;
    cls_t               w_dec_cls;
    logic               w_legal;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_boundary;
    logic               w_str_done;

    logic               r_imem_req,   w_imem_req;
    logic               r_dec_enable, w_dec_enable;
    logic               r_alu_en,     w_alu_en;
    logic               r_cpsr_we,    w_cpsr_we;
    logic               r_rf_we,      w_rf_we;
    logic [1:0]         r_wb_sel,     w_wb_sel;
    logic               r_dmem_req,   w_dmem_req;
    logic               r_dmem_we,    w_dmem_we;
    logic               r_pc_inc,     w_pc_inc;
    logic               r_pc_branch,  w_pc_branch;
    logic               r_fault,      w_fault;
    logic [1:0]         r_fault_code, w_fault_code;

    // Classify the decoder ALUCtl_code
    always_comb begin
        w_dec_cls      = '0;
        w_dec_cls.dp   = (alu_ctl <= OP_DP_MAX);
        w_dec_cls.cmp  = (alu_ctl == ALU_W'(8))  || (alu_ctl == ALU_W'(9)) ||
                         (alu_ctl == ALU_W'(10)) || (alu_ctl == ALU_W'(13));
        w_dec_cls.b    = (alu_ctl == OP_B);
        w_dec_cls.bl   = (alu_ctl == OP_BL);
        w_dec_cls.ldr  = (alu_ctl == OP_LDR);
        w_dec_cls.str  = (alu_ctl == OP_STR);
        w_dec_cls.cond = execute_flag;
        w_dec_cls.sbit = cpsr_enable;
    end

    assign w_legal = w_dec_cls.dp | w_dec_cls.b | w_dec_cls.bl | w_dec_cls.ldr | w_dec_cls.str;

    // Next-state, wait counter, class latch and fault code
    always_comb begin
        w_state_nxt  = r_state;
        w_cls_nxt    = r_cls;
        w_cnt_nxt    = r_cnt;
        w_fault_code = r_fault_code;
        w_boundary   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = S_DECODE;
                end else if (r_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt  = S_FAULT;
                    w_fault_code = FC_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_cls_nxt   = w_dec_cls;
                    w_state_nxt = S_EXECUTE;
                end else begin
                    w_state_nxt  = S_FAULT;
                    w_fault_code = FC_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                if (!r_cls.cond) begin
                    w_boundary = 1'b1;
                end else if (r_cls.dp) begin
                    if (r_cls.cmp) w_boundary  = 1'b1;
                    else           w_state_nxt = S_WRITEBACK;
                end else if (r_cls.bl) begin
                    w_state_nxt = S_WRITEBACK;
                end else if (r_cls.ldr || r_cls.str) begin
                    w_state_nxt = S_MEMORY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_boundary = 1'b1;
                end
            end
            S_MEMORY: begin
                if (dmem_ack) begin
                    if (r_cls.ldr) w_state_nxt = S_WRITEBACK;
                    else           w_boundary  = 1'b1;
                end else if (r_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt  = S_FAULT;
                    w_fault_code = FC_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WRITEBACK: begin
                w_boundary = 1'b1;
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_boundary) begin
            w_state_nxt = run ? S_FETCH : S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    // Moore output decode for the upcoming state, registered below
    always_comb begin
        w_imem_req   = 1'b0;
        w_dec_enable = 1'b0;
        w_alu_en     = 1'b0;
        w_cpsr_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_wb_sel     = WB_ALU;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_branch  = 1'b0;
        w_fault      = 1'b0;
        case (w_state_nxt)
            S_FETCH: begin
                w_imem_req = 1'b1;
            end
            S_DECODE: begin
                w_dec_enable = 1'b1;
            end
            S_EXECUTE: begin
                w_dec_enable = 1'b1;
                if (!w_cls_nxt.cond) begin
                    w_pc_inc = 1'b1;
                end else if (w_cls_nxt.dp) begin
                    w_alu_en  = 1'b1;
                    w_cpsr_we = w_cls_nxt.sbit | w_cls_nxt.cmp;
                    w_pc_inc  = w_cls_nxt.cmp;
                end else if (w_cls_nxt.b || w_cls_nxt.bl) begin
                    w_pc_branch = 1'b1;
                end else begin
                    w_alu_en = 1'b1;
                end
            end
            S_MEMORY: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_cls_nxt.str;
            end
            S_WRITEBACK: begin
                w_rf_we  = 1'b1;
                w_wb_sel = w_cls_nxt.ldr ? WB_MEM : (w_cls_nxt.bl ? WB_LINK : WB_ALU);
                w_pc_inc = !w_cls_nxt.bl;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, class, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cls        <= '0;
            r_cnt        <= '0;
            r_imem_req   <= 1'b0;
            r_dec_enable <= 1'b0;
            r_alu_en     <= 1'b0;
            r_cpsr_we    <= 1'b0;
            r_rf_we      <= 1'b0;
            r_wb_sel     <= WB_ALU;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_pc_inc     <= 1'b0;
            r_pc_branch  <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cls        <= w_cls_nxt;
            r_cnt        <= w_cnt_nxt;
            r_imem_req   <= w_imem_req;
            r_dec_enable <= w_dec_enable;
            r_alu_en     <= w_alu_en;
            r_cpsr_we    <= w_cpsr_we;
            r_rf_we      <= w_rf_we;
            r_wb_sel     <= w_wb_sel;
            r_dmem_req   <= w_dmem_req;
            r_dmem_we    <= w_dmem_we;
            r_pc_inc     <= w_pc_inc;
            r_pc_branch  <= w_pc_branch;
            r_fault      <= w_fault;
            r_fault_code <= w_fault_code;
        end
    end

    // A store retires in the cycle its data ack arrives, so its PC step follows the ack
    assign w_str_done = (r_state == S_MEMORY) && r_cls.str && dmem_ack;

    assign imem_req   = r_imem_req;
    assign ir_load    = r_imem_req & imem_ack;
    assign dec_enable = r_dec_enable;
    assign alu_en     = r_alu_en;
    assign cpsr_we    = r_cpsr_we;
    assign rf_we      = r_rf_we;
    assign wb_sel     = r_wb_sel;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign pc_inc     = r_pc_inc | w_str_done;
    assign pc_branch  = r_pc_branch;
    assign state      = r_state;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [RET_W-1:0] r_retired_cnt;

    // Count instruction boundaries; never advances once faulted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired_cnt <= '0;
        end else if (w_boundary) begin
            r_retired_cnt <= r_retired_cnt + RET_W'(1);
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: scoreboard bench for cpu_ctrl_fsm. Per-instruction model pushes
// cycle-by-cycle stimulus and expected outputs; the driver pops and compares each cycle.
module tb_cpu_ctrl_fsm;

    localparam int TO = 15;

    typedef struct packed {
        logic        run;
        logic        imem_ack;
        logic        dmem_ack;
        logic [10:0] alu_ctl;
        logic        execute_flag;
        logic        cpsr_enable;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_load;
        logic       dec_enable;
        logic       alu_en;
        logic       cpsr_we;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_inc;
        logic       pc_branch;
        logic       fault;
        logic [1:0] fault_code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        ir_load;
    logic        dec_enable;
    logic [10:0] alu_ctl = '0;
    logic        execute_flag = 1'b0;
    logic        cpsr_enable = 1'b0;
    logic        alu_en;
    logic        cpsr_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        pc_inc;
    logic        pc_branch;
    logic [2:0]  state;
    logic        fault;
    logic [1:0]  fault_code;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    bit    g_noise = 1'b0;
    stim_t sq[$];
    exp_t  eq[$];
    string nq[$];

    cpu_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .ir_load      (ir_load),
        .dec_enable   (dec_enable),
        .alu_ctl      (alu_ctl),
        .execute_flag (execute_flag),
        .cpsr_enable  (cpsr_enable),
        .alu_en       (alu_en),
        .cpsr_we      (cpsr_we),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .pc_inc       (pc_inc),
        .pc_branch    (pc_branch),
        .state        (state),
        .fault        (fault),
`ifdef CPU_CTRL_RETIRE_CNT_EN
        .retired_cnt  (retired_cnt),
`endif
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic exp_t exp_st(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic nz();
        return g_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.st         = state;
        o.imem_req   = imem_req;
        o.ir_load    = ir_load;
        o.dec_enable = dec_enable;
        o.alu_en     = alu_en;
        o.cpsr_we    = cpsr_we;
        o.rf_we      = rf_we;
        o.wb_sel     = wb_sel;
        o.dmem_req   = dmem_req;
        o.dmem_we    = dmem_we;
        o.pc_inc     = pc_inc;
        o.pc_branch  = pc_branch;
        o.fault      = fault;
        o.fault_code = fault_code;
        return o;
    endfunction

    task automatic push(input stim_t s, input exp_t e, input string n);
        sq.push_back(s);
        eq.push_back(e);
        nq.push_back(n);
    endtask

    task automatic gen_idle(input bit r);
        stim_t s;
        s          = '0;
        s.run      = r;
        s.imem_ack = nz();
        s.dmem_ack = nz();
        push(s, exp_st(3'd0), "idle");
    endtask

    task automatic gen_fault(input logic [1:0] code);
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 4; i++) begin
            s            = '0;
            s.run        = 1'b1;
            s.imem_ack   = 1'b1;
            s.dmem_ack   = 1'b1;
            e            = exp_st(3'd6);
            e.fault      = 1'b1;
            e.fault_code = code;
            push(s, e, "fault");
        end
    endtask

    // Reference model of one instruction, from FETCH through its boundary (or FAULT)
    task automatic gen_instr(input logic [10:0] code, input bit cond, input bit sb,
                             input int iw, input int dw, input bit run_end);
        stim_t s;
        exp_t  e;
        bit dp, cmp, b, bl, ldr, str;
        dp  = (code <= 11'd13);
        cmp = (code == 11'd8) || (code == 11'd9) || (code == 11'd10) || (code == 11'd13);
        b   = (code == 11'd31);
        bl  = (code == 11'd32);
        ldr = (code == 11'd41);
        str = (code == 11'd42);
        s              = '0;
        s.run          = run_end;
        s.alu_ctl      = code;
        s.execute_flag = cond;
        s.cpsr_enable  = sb;
        for (int i = 0; i <= iw && i <= TO; i++) begin
            s.imem_ack = (i == iw);
            s.dmem_ack = nz();
            e          = exp_st(3'd1);
            e.imem_req = 1'b1;
            e.ir_load  = (i == iw);
            push(s, e, "fetch");
        end
        if (iw > TO) begin
            gen_fault(2'd1);
            return;
        end
        s.imem_ack   = nz();
        s.dmem_ack   = nz();
        e            = exp_st(3'd2);
        e.dec_enable = 1'b1;
        push(s, e, "decode");
        if (!(dp || b || bl || ldr || str)) begin
            gen_fault(2'd3);
            return;
        end
        s.imem_ack   = nz();
        s.dmem_ack   = nz();
        e            = exp_st(3'd3);
        e.dec_enable = 1'b1;
        if (!cond) begin
            e.pc_inc = 1'b1;
        end else if (dp) begin
            e.alu_en  = 1'b1;
            e.cpsr_we = sb || cmp;
            e.pc_inc  = cmp;
        end else if (b || bl) begin
            e.pc_branch = 1'b1;
        end else begin
            e.alu_en = 1'b1;
        end
        push(s, e, "execute");
        if (!cond || cmp || b) return;
        if (ldr || str) begin
            for (int i = 0; i <= dw && i <= TO; i++) begin
                s.imem_ack = nz();
                s.dmem_ack = (i == dw);
                e          = exp_st(3'd4);
                e.dmem_req = 1'b1;
                e.dmem_we  = str;
                e.pc_inc   = str && (i == dw);
                push(s, e, "memory");
            end
            if (dw > TO) begin
                gen_fault(2'd2);
                return;
            end
            if (str) return;
        end
        s.imem_ack = nz();
        s.dmem_ack = nz();
        e          = exp_st(3'd5);
        e.rf_we    = 1'b1;
        e.wb_sel   = ldr ? 2'd1 : (bl ? 2'd2 : 2'd0);
        e.pc_inc   = !bl;
        push(s, e, "writeback");
    endtask

    task automatic drive(input stim_t s);
        run          = s.run;
        imem_ack     = s.imem_ack;
        dmem_ack     = s.dmem_ack;
        alu_ctl      = s.alu_ctl;
        execute_flag = s.execute_flag;
        cpsr_enable  = s.cpsr_enable;
    endtask

    // Pop stimulus/expectation pairs one cycle at a time and compare
    task automatic drain();
        stim_t s;
        exp_t  e;
        exp_t  o;
        string n;
        while (sq.size() > 0) begin
            @(negedge clk);
            s = sq.pop_front();
            drive(s);
            #1;
            e = eq.pop_front();
            n = nq.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, o, e);
            end
        end
    endtask

    task automatic do_reset();
        exp_t o;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        o = observe();
        n_checks++;
        if (o !== exp_st(3'd0)) begin
            n_errors++;
            $display("FAIL reset_async: got %h expected %h", o, exp_st(3'd0));
        end
        drive('0);
        @(posedge clk);
        #1;
        o = observe();
        n_checks++;
        if (o !== exp_st(3'd0)) begin
            n_errors++;
            $display("FAIL reset_hold: got %h expected %h", o, exp_st(3'd0));
        end
`ifdef CPU_CTRL_RETIRE_CNT_EN
        n_checks++;
        if (retired_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_retired: got %h expected 0", retired_cnt);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t o;
        reset_n = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        o = observe();
        n_checks++;
        if (o !== exp_st(3'd0)) begin
            n_errors++;
            $display("FAIL reset_init: got %h expected %h", o, exp_st(3'd0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        gen_idle(1'b0);
        gen_idle(1'b0);
        drain();
    endtask

    task automatic test_dp();
        gen_idle(1'b1);
        gen_instr(11'd0, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd4, 1'b1, 1'b1, 1, 0, 1'b1);
        gen_instr(11'd12, 1'b1, 1'b0, 0, 0, 1'b0);
        gen_idle(1'b0);
        drain();
    endtask

    task automatic test_cmp_branch();
        gen_idle(1'b1);
        gen_instr(11'd8, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd13, 1'b1, 1'b1, 0, 0, 1'b1);
        gen_instr(11'd31, 1'b0, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd31, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd0, 1'b0, 1'b1, 0, 0, 1'b0);
        gen_idle(1'b0);
        drain();
    endtask

    task automatic test_mem_link();
        gen_idle(1'b1);
        gen_instr(11'd41, 1'b1, 1'b0, 0, 3, 1'b1);
        gen_instr(11'd42, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd42, 1'b1, 1'b0, 2, 2, 1'b1);
        gen_instr(11'd32, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd32, 1'b0, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd41, 1'b1, 1'b0, 0, 1, 1'b0);
        gen_idle(1'b0);
        gen_idle(1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [10:0] ops [11];
        ops = '{11'd0, 11'd4, 11'd8, 11'd9, 11'd10, 11'd13, 11'd12,
                11'd31, 11'd32, 11'd41, 11'd42};
        g_noise = 1'b1;
        gen_idle(1'b1);
        for (int k = 0; k < 24; k++) begin
            gen_instr(ops[$urandom_range(0, 10)], ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), (k != 23));
        end
        gen_idle(1'b0);
        drain();
        g_noise = 1'b0;
    endtask

    task automatic test_timeouts();
        gen_idle(1'b1);
        gen_instr(11'd0, 1'b1, 1'b0, TO + 1, 0, 1'b1);
        drain();
        do_reset();
        gen_idle(1'b1);
        gen_instr(11'd0, 1'b1, 1'b0, TO, 0, 1'b1);
        gen_instr(11'd41, 1'b1, 1'b0, 0, TO, 1'b0);
        gen_idle(1'b0);
        drain();
        gen_idle(1'b1);
        gen_instr(11'd42, 1'b1, 1'b0, 0, TO + 1, 1'b1);
        drain();
        do_reset();
        gen_idle(1'b1);
        gen_instr(11'd20, 1'b1, 1'b0, 0, 0, 1'b1);
        drain();
        do_reset();
        gen_idle(1'b1);
        gen_instr(11'd14, 1'b1, 1'b0, 0, 0, 1'b1);
        drain();
        do_reset();
        gen_idle(1'b1);
        gen_instr(11'd43, 1'b1, 1'b0, 0, 0, 1'b1);
        drain();
        do_reset();
    endtask

    task automatic test_reset_mid();
        exp_t o;
        gen_idle(1'b1);
        gen_instr(11'd41, 1'b1, 1'b0, 0, 5, 1'b1);
        repeat (5) begin
            void'(sq.pop_back());
            void'(eq.pop_back());
            void'(nq.pop_back());
        end
        drain();
        @(posedge clk);
        #2;
        n_checks++;
        if (dmem_req !== 1'b1 || state !== 3'd4) begin
            n_errors++;
            $display("FAIL mid_mem: got dmem_req %b state %0d expected 1 and 4", dmem_req, state);
        end
        reset_n = 1'b0;
        #1;
        o = observe();
        n_checks++;
        if (o !== exp_st(3'd0)) begin
            n_errors++;
            $display("FAIL mid_reset: got %h expected %h", o, exp_st(3'd0));
        end
        dmem_ack = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            o = observe();
            n_checks++;
            if (o !== exp_st(3'd0)) begin
                n_errors++;
                $display("FAIL mid_reset_hold: got %h expected %h", o, exp_st(3'd0));
            end
        end
        @(negedge clk);
        drive('0);
        reset_n = 1'b1;
        gen_idle(1'b1);
        gen_instr(11'd41, 1'b1, 1'b0, 0, 2, 1'b0);
        gen_idle(1'b0);
        gen_idle(1'b0);
        drain();
    endtask

`ifdef CPU_CTRL_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        do_reset();
        gen_idle(1'b1);
        gen_instr(11'd0, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd8, 1'b1, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd31, 1'b0, 1'b0, 0, 0, 1'b1);
        gen_instr(11'd41, 1'b1, 1'b0, 0, 1, 1'b1);
        gen_instr(11'd42, 1'b1, 1'b0, 0, 0, 1'b0);
        gen_idle(1'b0);
        drain();
        n_checks++;
        if (retired_cnt !== 32'd5) begin
            n_errors++;
            $display("FAIL retired_five: got %0d expected 5", retired_cnt);
        end
        @(negedge clk);
        force dut.r_retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_cnt;
        gen_idle(1'b1);
        gen_instr(11'd0, 1'b1, 1'b0, 0, 0, 1'b0);
        gen_idle(1'b0);
        drain();
        n_checks++;
        if (retired_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL retired_wrap: got %h expected 0", retired_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_dp();
        test_cmp_branch();
        test_mem_link();
        test_back_to_back();
        test_timeouts();
        test_reset_mid();
`ifdef CPU_CTRL_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
